param_memory: RTL and testbench



---
 rtl/param_memory_if.sv | 41 ++++
 rtl/param_memory.sv | 93 +++++++++
 tb/tb_param_memory.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/param_memory_if.sv
// Request/response bundle for param_memory.
//
// Handshake: there is no ready signal. A request (wr and/or rd with a and
// d_in) is presented for one cycle and is taken at the next rising edge
// when busy is low; while busy is high the request is silently dropped.
// Responses are registered: q/valid/err reflect the request sampled at the
// previous edge.
//
// Signals:
//   wr, rd   request strobes (master -> slave)
//   a        word address
//   d_in     write data
//   q        registered read data
//   valid    one-cycle strobe, q updated by a read
//   busy     clear sequence running, requests ignored
//   err      one-cycle strobe, previous request was out of range
//   state    debug view of the controller state (0 = CLEAR, 1 = READY)
interface param_memory_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) ();
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] q;
  logic              valid;
  logic              busy;
  logic              err;
  logic              state;

  modport master (
    output wr, rd, a, d_in,
    input  q, valid, busy, err, state
  );

  modport slave (
    input  wr, rd, a, d_in,
    output q, valid, busy, err, state
  );
endinterface

// File: rtl/param_memory.sv
// Parametrised single-port synchronous memory with a post-reset clear
// sequencer.
//
// After reset every implemented word is written with zero, one word per
// edge, while busy is high. Afterwards reads are registered (one-cycle
// latency, valid strobe) and a simultaneous write+read to the same word
// returns the new data (write-first). Addresses >= DEPTH are never written,
// read back as zero and raise err for one cycle.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rstn   synchronous active-low reset
//   bus    param_memory_if slave modport (wr, rd, a, d_in, q, valid,
//          busy, err, state)
module param_memory #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input logic           clk,
  input logic           rstn,
  param_memory_if.slave bus
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Counter is one bit wider than the address so DEPTH = 2**ADDR_W can be
  // represented and compared against without wrapping.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state;
  logic [ADDR_W:0]   cnt;

  logic              clearing;
  logic              in_range;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign clearing = (state == ST_CLEAR);
  assign in_range = ({1'b0, bus.a} < DEPTH_W);

  // One write port shared between the clear sequencer and user writes.
  assign we    = rstn && (clearing || (bus.wr && in_range));
  assign waddr = clearing ? cnt[ADDR_W-1:0] : bus.a;
  assign wdata = clearing ? '0 : bus.d_in;

  assign bus.state = state[0];

  // Storage has no reset: reset only restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_CLEAR;
      cnt       <= '0;
      bus.q     <= '0;
      bus.valid <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b1;
    end else if (clearing) begin
      bus.valid <= 1'b0;
      bus.err   <= 1'b0;
      cnt       <= cnt + ONE;
      if (cnt == LAST) begin
        state    <= ST_READY;
        bus.busy <= 1'b0;
      end
    end else begin
      bus.valid <= bus.rd;
      bus.err   <= (bus.wr || bus.rd) && !in_range;
      if (bus.rd) begin
        if (!in_range) begin
          bus.q <= '0;
        end else if (bus.wr) begin
          bus.q <= bus.d_in;
        end else begin
          bus.q <= mem[bus.a];
        end
      end
    end
  end

endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory. Three configurations run side by side from one
// shared stimulus stream:
//   k=0: DATA_W=4,  ADDR_W=4, DEPTH=16
//   k=1: DATA_W=4,  ADDR_W=4, DEPTH=12 (out-of-range addresses exist)
//   k=2: DATA_W=16, ADDR_W=6, DEPTH=64
// Inputs change on the falling edge; outputs are checked on the falling
// edge against a behavioural model updated on the rising edge.
module tb_param_memory;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;
  logic wr;
  logic rd;
  logic [5:0]  a_in;
  logic [15:0] d_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  param_memory_if #(.DATA_W(4),  .ADDR_W(4)) if0 ();
  param_memory_if #(.DATA_W(4),  .ADDR_W(4)) if1 ();
  param_memory_if #(.DATA_W(16), .ADDR_W(6)) if2 ();

  assign if0.wr = wr;  assign if0.rd = rd;  assign if0.a = a_in[3:0];  assign if0.d_in = d_in[3:0];
  assign if1.wr = wr;  assign if1.rd = rd;  assign if1.a = a_in[3:0];  assign if1.d_in = d_in[3:0];
  assign if2.wr = wr;  assign if2.rd = rd;  assign if2.a = a_in;       assign if2.d_in = d_in;

  param_memory #(.DATA_W(4),  .ADDR_W(4), .DEPTH(16)) dut0 (.clk(clk), .rstn(rstn), .bus(if0));
  param_memory #(.DATA_W(4),  .ADDR_W(4), .DEPTH(12)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
  param_memory #(.DATA_W(16), .ADDR_W(6), .DEPTH(64)) dut2 (.clk(clk), .rstn(rstn), .bus(if2));

  logic [15:0] act_q [3];
  logic        act_v [3];
  logic        act_b [3];
  logic        act_e [3];

  assign act_q[0] = {12'h000, if0.q};
  assign act_q[1] = {12'h000, if1.q};
  assign act_q[2] = if2.q;
  assign act_v[0] = if0.valid;  assign act_v[1] = if1.valid;  assign act_v[2] = if2.valid;
  assign act_b[0] = if0.busy;   assign act_b[1] = if1.busy;   assign act_b[2] = if2.busy;
  assign act_e[0] = if0.err;    assign act_e[1] = if1.err;    assign act_e[2] = if2.err;

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          depth_k [3] = '{16, 12, 64};
  logic [5:0]  amask   [3] = '{6'h0F, 6'h0F, 6'h3F};
  logic [15:0] dmask   [3] = '{16'h000F, 16'h000F, 16'hFFFF};

  logic [15:0] m_mem   [3][64];
  int          m_busy  [3] = '{0, 0, 0};
  logic [15:0] m_q     [3];
  logic        m_valid [3];
  logic        m_err   [3];
  logic        live = 1'b0;

  always @(posedge clk) begin
    int          ak;
    logic [15:0] dk;
    logic        inr;
    if (!rstn) live = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ak  = int'(a_in & amask[k]);
      dk  = d_in & dmask[k];
      inr = (ak < depth_k[k]);
      if (!rstn) begin
        m_busy[k]  = depth_k[k];
        m_q[k]     = 16'h0000;
        m_valid[k] = 1'b0;
        m_err[k]   = 1'b0;
      end else if (m_busy[k] > 0) begin
        m_mem[k][depth_k[k] - m_busy[k]] = 16'h0000;
        m_busy[k]  = m_busy[k] - 1;
        m_valid[k] = 1'b0;
        m_err[k]   = 1'b0;
      end else begin
        m_valid[k] = rd;
        m_err[k]   = (wr || rd) && !inr;
        if (rd) m_q[k] = !inr ? 16'h0000 : (wr ? dk : m_mem[k][ak]);
        if (wr && inr) m_mem[k][ak] = dk;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (live) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy%0d", k),  {15'h0, act_b[k]}, {15'h0, (m_busy[k] > 0)});
        chk($sformatf("valid%0d", k), {15'h0, act_v[k]}, {15'h0, m_valid[k]});
        chk($sformatf("err%0d", k),   {15'h0, act_e[k]}, {15'h0, m_err[k]});
        chk($sformatf("q%0d", k),     act_q[k], m_q[k]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic w, input logic rr,
                      input logic [5:0] aa, input logic [15:0] dd);
    rstn = r; wr = w; rd = rr; a_in = aa; d_in = dd;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts idle edges after a reset edge until each instance drops busy.
  task automatic measure_busy(input string tag);
    int done_at [3];
    done_at = '{-1, -1, -1};
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
      for (int k = 0; k < 3; k++)
        if (done_at[k] < 0 && !act_b[k]) done_at[k] = i;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_len%0d", tag, k), 16'(done_at[k]), 16'(depth_k[k]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b1; wr = 1'b0; rd = 1'b0; a_in = '0; d_in = '0;
    @(negedge clk);

    // Reset and clear, then every address of the 16-deep instance reads 0.
    step(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
    chk("rst_q0", act_q[0], 16'h0000);
    chk("rst_busy0", {15'h0, act_b[0]}, 16'h0001);
    measure_busy("clr");
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b1, 6'(i), 16'h0);
      chk($sformatf("clr_rd%0d", i), act_q[0], 16'h0000);
      chk($sformatf("clr_v%0d", i), {15'h0, act_v[0]}, 16'h0001);
    end

    // Plain write then read.
    step(1'b1, 1'b1, 1'b0, 6'd3,  16'd9);
    step(1'b1, 1'b1, 1'b0, 6'd13, 16'd10);
    step(1'b1, 1'b0, 1'b1, 6'd3,  16'h0);
    chk("rd3_q", act_q[0], 16'd9);
    chk("rd3_model", m_q[0], 16'd9);
    step(1'b1, 1'b0, 1'b1, 6'd13, 16'h0);
    chk("rd13_q", act_q[0], 16'd10);
    chk("rd13_v", {15'h0, act_v[0]}, 16'h0001);
    step(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    chk("hold_q", act_q[0], 16'd10);
    chk("hold_v", {15'h0, act_v[0]}, 16'h0000);

    // Write-first collision.
    step(1'b1, 1'b1, 1'b0, 6'd5, 16'd2);
    step(1'b1, 1'b1, 1'b1, 6'd5, 16'd7);
    chk("coll_q", act_q[0], 16'd7);
    chk("coll_v", {15'h0, act_v[0]}, 16'h0001);
    step(1'b1, 1'b0, 1'b1, 6'd5, 16'h0);
    chk("coll_rd", act_q[0], 16'd7);

    // Out of range on the 12-deep instance.
    step(1'b1, 1'b1, 1'b0, 6'd14, 16'd6);
    chk("oor_wr_err", {15'h0, act_e[1]}, 16'h0001);
    step(1'b1, 1'b0, 1'b1, 6'd14, 16'h0);
    chk("oor_rd_q", act_q[1], 16'h0000);
    chk("oor_rd_v", {15'h0, act_v[1]}, 16'h0001);
    chk("oor_rd_err", {15'h0, act_e[1]}, 16'h0001);
    chk("inr_err0", {15'h0, act_e[0]}, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 6'd11, 16'd4);
    step(1'b1, 1'b0, 1'b1, 6'd11, 16'h0);
    chk("rd11_q", act_q[1], 16'd4);
    chk("rd11_err", {15'h0, act_e[1]}, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    chk("err_drop", {15'h0, act_e[1]}, 16'h0000);

    // Wide instance: extreme addresses and data.
    step(1'b1, 1'b1, 1'b0, 6'd63, 16'hA5C3);
    step(1'b1, 1'b1, 1'b0, 6'd0,  16'h0001);
    step(1'b1, 1'b0, 1'b1, 6'd63, 16'h0);
    chk("wide63", act_q[2], 16'hA5C3);
    chk("wide63_model", m_q[2], 16'hA5C3);
    step(1'b1, 1'b0, 1'b1, 6'd0, 16'h0);
    chk("wide0", act_q[2], 16'h0001);

    // Busy lockout and mid-clear reset.
    step(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 6'd0, 16'hFFFF);
    chk("lock_v", {15'h0, act_v[0]}, 16'h0000);
    for (int i = 4; i < 10; i++) step(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
    measure_busy("mid");
    step(1'b1, 1'b0, 1'b1, 6'd0, 16'h0);
    chk("lock_rd0", act_q[0], 16'h0000);
    chk("lock_rd0_w", act_q[2], 16'h0000);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
